// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - register map, CTRL/STATUS bit positions and FSM encoding for spi_target
package spi_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int CTRL_EN_BIT     = 15;
    localparam int CTRL_CPHA_BIT   = 16;
    localparam int CTRL_CPOL_BIT   = 17;
    localparam int CTRL_RXIE_BIT   = 18;
    localparam int CTRL_TXEIE_BIT  = 19;
    localparam int CTRL_MISOHI_BIT = 20;
    localparam logic [31:0] CTRL_MASK = 32'h001F_801F;

    localparam int STAT_RXFE      = 0;
    localparam int STAT_RXFF      = 1;
    localparam int STAT_RXFO      = 2;
    localparam int STAT_TXE       = 3;
    localparam int STAT_TXU       = 4;
    localparam int STAT_FERR      = 5;
    localparam int STAT_BUSY      = 6;
    localparam int STAT_LEVEL_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - 32-bit RX FIFO; a pop on a full FIFO frees room for a same-cycle push
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [31:0]                push_data_i,
    input  logic                       pop_i,
    output logic [31:0]                head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o    = (level_q == '0);
    assign full_o     = (level_q == (AW+1)'(DEPTH));
    assign do_pop     = pop_i & ~empty_o;
    assign do_push    = push_i & (~full_o | do_pop);
    assign overflow_o = push_i & full_o & ~do_pop;
    assign level_o    = level_q;
    assign head_o     = empty_o ? 32'd0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI target with Avalon-MM register port, RX FIFO and TX holding register
module spi_target
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic        chipselect,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        spi_clk,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        irq
);

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic cs_prev_q, sclk_prev_q;
    logic cs_s, sclk_s, mosi_s, cs_fall, cs_rise, sclk_rise, sclk_fall;

    spi_state_e  state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
    logic        miso_q, miso_d, push_q, push_d;
    logic        word_start, drive_bit, ferr_set;

    logic [31:0] ctrl_q, tx_q, status_w, fifo_head;
    logic        txe_q, rxfo_q, txu_q, ferr_q, irq_q;
    logic        fifo_full, fifo_empty, fifo_ovf;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic [3:0]  level_field;

    logic [4:0] word_size;
    logic ctrl_en, cpol, cpha, sample_rise, sample_edge, launch_edge;
    logic wr_data, wr_status, wr_ctrl, rd_data;

    assign word_size = ctrl_q[4:0];
    assign ctrl_en   = ctrl_q[CTRL_EN_BIT];
    assign cpol      = ctrl_q[CTRL_CPOL_BIT];
    assign cpha      = ctrl_q[CTRL_CPHA_BIT];

    assign wr_data   = chipselect & write & (address == ADDR_DATA);
    assign wr_status = chipselect & write & (address == ADDR_STATUS);
    assign wr_ctrl   = chipselect & write & (address == ADDR_CTRL);
    assign rd_data   = chipselect & read  & (address == ADDR_DATA);

    // cs idles high in the synchronizer so reset never fabricates a cs falling edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= (cs_sync_q << 1)   | SYNC_STAGES'(spi_cs);
            sclk_sync_q <= (sclk_sync_q << 1) | SYNC_STAGES'(spi_clk);
            mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(spi_mosi);
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    // modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge
    assign sample_rise = (cpol == cpha);
    assign sample_edge = sample_rise ? sclk_rise : sclk_fall;
    assign launch_edge = sample_rise ? sclk_fall : sclk_rise;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        miso_d     = miso_q;
        push_d     = 1'b0;
        word_start = 1'b0;
        drive_bit  = 1'b0;
        ferr_set   = 1'b0;
        if (!ctrl_en) begin
            state_d = S_IDLE;
        end else if (cs_rise) begin
            ferr_set = (state_q == S_SHIFT) && (bit_cnt_q != 5'd0);
            state_d  = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_fall) begin
                        state_d    = S_SHIFT;
                        word_start = 1'b1;
                        drive_bit  = ~cpha;
                    end
                end
                S_SHIFT: begin
                    if (sample_edge) begin
                        rx_sr_d   = {rx_sr_q[30:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == word_size) begin
                            state_d = S_HOLD;
                            push_d  = 1'b1;
                        end
                    end else if (launch_edge) begin
                        drive_bit = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (launch_edge) begin
                        state_d    = S_SHIFT;
                        word_start = 1'b1;
                        drive_bit  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // TX word is left-justified so bit 31 is always the next bit to launch
        if (word_start) begin
            tx_sr_d   = txe_q ? 32'd0 : (tx_q << (5'd31 - word_size));
            rx_sr_d   = '0;
            bit_cnt_d = '0;
        end
        if (drive_bit) begin
            miso_d  = tx_sr_d[31];
            tx_sr_d = {tx_sr_d[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            miso_q    <= 1'b0;
            push_q    <= 1'b0;
            ctrl_q    <= '0;
            tx_q      <= '0;
            txe_q     <= 1'b1;
            rxfo_q    <= 1'b0;
            txu_q     <= 1'b0;
            ferr_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            miso_q    <= miso_d;
            push_q    <= push_d;
            if (wr_ctrl) ctrl_q <= writedata & CTRL_MASK;
            if (wr_data) begin
                tx_q  <= writedata;
                txe_q <= 1'b0;
            end else if (word_start) begin
                txe_q <= 1'b1;
            end
            rxfo_q <= (rxfo_q & ~(wr_status & writedata[STAT_RXFO])) | fifo_ovf;
            txu_q  <= (txu_q  & ~(wr_status & writedata[STAT_TXU]))  | (word_start & txe_q);
            ferr_q <= (ferr_q & ~(wr_status & writedata[STAT_FERR])) | ferr_set;
            irq_q  <= (ctrl_q[CTRL_RXIE_BIT] & ~fifo_empty) | (ctrl_q[CTRL_TXEIE_BIT] & txe_q)
                    | rxfo_q | txu_q | ferr_q;
        end
    end

    spi_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (push_q),
        .push_data_i (rx_sr_q),
        .pop_i       (rd_data),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level),
        .overflow_o  (fifo_ovf)
    );

    assign level_field = (32'(fifo_level) > 32'd15) ? 4'hF : 4'(fifo_level);

    always_comb begin
        status_w = '0;
        status_w[STAT_RXFE] = fifo_empty;
        status_w[STAT_RXFF] = fifo_full;
        status_w[STAT_RXFO] = rxfo_q;
        status_w[STAT_TXE]  = txe_q;
        status_w[STAT_TXU]  = txu_q;
        status_w[STAT_FERR] = ferr_q;
        status_w[STAT_BUSY] = (state_q != S_IDLE);
        status_w[STAT_LEVEL_LSB +: 4] = level_field;
    end

    always_comb begin
        readdata = '0;
        if (read && chipselect) begin
            case (address)
                ADDR_DATA:   readdata = fifo_head;
                ADDR_STATUS: readdata = status_w;
                ADDR_CTRL:   readdata = ctrl_q;
                default:     readdata = '0;
            endcase
        end
    end

    assign spi_miso = (state_q == S_IDLE) ? ctrl_q[CTRL_MISOHI_BIT] : miso_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - directed self-checking bench for spi_target
module tb_spi_target;

    localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read = 1'b0, write = 1'b0, chipselect = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        spi_clk = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0;
    logic        spi_miso, irq;

    int checks = 0;
    int failures = 0;
    logic [31:0] rd, m, co_rd_data;
    logic        mb;

    spi_target #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .read       (read),
        .write      (write),
        .chipselect (chipselect),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .spi_clk    (spi_clk),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .irq        (irq)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1; chipselect = 1'b1;
        @(negedge clk);
        write = 1'b0; chipselect = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; read = 1'b1; chipselect = 1'b1;
        #1 d = readdata;
        @(negedge clk);
        read = 1'b0; chipselect = 1'b0;
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    // co_rd issues a DATA read timed to land on the same clk edge as the resulting FIFO push
    task automatic spi_bit(input logic cpol, input logic cpha, input logic b, input logic last,
                           input logic co_rd, output logic mo);
        if (!cpha) begin
            spi_mosi = b;
            half();
        end else begin
            spi_clk = ~cpol;
            spi_mosi = b;
            half();
        end
        mo = spi_miso;
        spi_clk = cpha ? cpol : ~cpol;
        if (co_rd) begin
            repeat (2) @(negedge clk);
            bus_read(A_DATA, co_rd_data);
            repeat (4) @(negedge clk);
        end else begin
            half();
        end
        if (!cpha && !last) spi_clk = cpol;
    endtask

    task automatic spi_start();
        spi_cs = 1'b0;
        half();
    endtask

    task automatic spi_stop(input logic cpol);
        half();
        spi_cs = 1'b1;
        half();
        spi_clk = cpol;
        half();
    endtask

    task automatic spi_word(input logic cpol, input logic cpha, input int nbits, input int send,
                            input logic [31:0] d, input logic co_rd, output logic [31:0] mo);
        logic bit_o;
        mo = '0;
        for (int i = nbits - 1; i >= nbits - send; i--) begin
            spi_bit(cpol, cpha, d[i], i == nbits - send, co_rd && (i == 0), bit_o);
            mo = {mo[30:0], bit_o};
        end
    endtask

    task automatic spi_frame(input logic cpol, input logic cpha, input int nbits,
                             input logic [31:0] d, input logic co_rd, output logic [31:0] mo);
        spi_start();
        spi_word(cpol, cpha, nbits, nbits, d, co_rd, mo);
        spi_stop(cpol);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);

        // reset state
        bus_read(A_STATUS, rd); check_eq("rst_status", rd, 32'h09);
        bus_read(A_CTRL, rd);   check_eq("rst_ctrl", rd, 32'h0);
        bus_read(A_DATA, rd);   check_eq("rst_data_empty", rd, 32'h0);
        check_eq("rst_miso", {31'd0, spi_miso}, 32'h0);
        check_eq("rst_irq", {31'd0, irq}, 32'h0);

        // mode 0, 8-bit word, RX_IE
        bus_write(A_CTRL, 32'h0004_8007);
        bus_read(A_CTRL, rd);   check_eq("m0_ctrl", rd, 32'h0004_8007);
        bus_write(A_DATA, 32'hA5);
        bus_read(A_STATUS, rd); check_eq("m0_txe_clr", rd, 32'h01);
        check_eq("m0_irq_idle", {31'd0, irq}, 32'h0);
        spi_frame(1'b0, 1'b0, 8, 32'h3C, 1'b0, m);
        check_eq("m0_miso_word", m, 32'hA5);
        bus_read(A_STATUS, rd); check_eq("m0_status", rd, 32'h108);
        check_eq("m0_irq_rx", {31'd0, irq}, 32'h1);
        bus_read(A_DATA, rd);   check_eq("m0_data", rd, 32'h3C);
        bus_read(A_STATUS, rd); check_eq("m0_rxfe", rd, 32'h09);
        repeat (2) @(negedge clk);
        check_eq("m0_irq_clr", {31'd0, irq}, 32'h0);

        // MISO idle level
        bus_write(A_CTRL, 32'h0010_8007);
        repeat (2) @(negedge clk);
        check_eq("miso_idle_hi", {31'd0, spi_miso}, 32'h1);
        bus_write(A_CTRL, 32'h0000_8007);
        repeat (2) @(negedge clk);
        check_eq("miso_idle_lo", {31'd0, spi_miso}, 32'h0);

        // mode 3, 32-bit word, TX underrun
        bus_write(A_CTRL, 32'h0003_801F);
        spi_clk = 1'b1;
        repeat (6) @(negedge clk);
        spi_frame(1'b1, 1'b1, 32, 32'hDEADBEEF, 1'b0, m);
        check_eq("m3_miso_zero", m, 32'h0);
        bus_read(A_STATUS, rd); check_eq("m3_status", rd, 32'h118);
        check_eq("m3_irq", {31'd0, irq}, 32'h1);
        bus_read(A_DATA, rd);   check_eq("m3_data", rd, 32'hDEADBEEF);
        bus_write(A_STATUS, 32'h10);
        bus_read(A_STATUS, rd); check_eq("m3_txu_clr", rd, 32'h09);
        repeat (2) @(negedge clk);
        check_eq("m3_irq_clr", {31'd0, irq}, 32'h0);
        bus_write(A_CTRL, 32'h0000_8007);
        spi_clk = 1'b0;
        repeat (6) @(negedge clk);

        // partial frame then a clean one
        bus_write(A_DATA, 32'h0F);
        spi_start();
        spi_word(1'b0, 1'b0, 8, 5, 32'h55, 1'b0, m);
        spi_stop(1'b0);
        bus_read(A_STATUS, rd); check_eq("ferr_status", rd, 32'h29);
        check_eq("ferr_irq", {31'd0, irq}, 32'h1);
        bus_write(A_STATUS, 32'h20);
        bus_read(A_STATUS, rd); check_eq("ferr_clr", rd, 32'h09);
        bus_write(A_DATA, 32'hC3);
        spi_frame(1'b0, 1'b0, 8, 32'h55, 1'b0, m);
        check_eq("ferr_next_miso", m, 32'hC3);
        bus_read(A_STATUS, rd); check_eq("ferr_next_status", rd, 32'h108);
        bus_read(A_DATA, rd);   check_eq("ferr_next_data", rd, 32'h55);

        // overflow: nine words into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) spi_frame(1'b0, 1'b0, 8, 32'(i), 1'b0, m);
        bus_read(A_STATUS, rd); check_eq("ovf_status", rd, 32'h81E);
        for (int i = 1; i <= 8; i++) begin
            bus_read(A_DATA, rd); check_eq("ovf_data", rd, 32'(i));
        end
        bus_read(A_STATUS, rd); check_eq("ovf_drained", rd, 32'h1D);
        bus_write(A_STATUS, 32'h14);
        bus_read(A_STATUS, rd); check_eq("ovf_clr", rd, 32'h09);

        // full FIFO, DATA read coincident with the ninth push
        for (int i = 0; i < 8; i++) spi_frame(1'b0, 1'b0, 8, 32'h11 + 32'(i), 1'b0, m);
        bus_read(A_STATUS, rd); check_eq("co_full", rd, 32'h81A);
        spi_frame(1'b0, 1'b0, 8, 32'h19, 1'b1, m);
        check_eq("co_rd_head", co_rd_data, 32'h11);
        bus_read(A_STATUS, rd); check_eq("co_status", rd, 32'h81A);
        for (int i = 0; i < 8; i++) begin
            bus_read(A_DATA, rd); check_eq("co_data", rd, 32'h12 + 32'(i));
        end
        bus_write(A_STATUS, 32'h10);
        bus_read(A_STATUS, rd); check_eq("co_clr", rd, 32'h09);

        // reset mid-word
        bus_write(A_DATA, 32'h0F);
        d = 32'hE7;
        spi_start();
        for (int i = 7; i >= 5; i--) spi_bit(1'b0, 1'b0, d[i], 1'b0, 1'b0, mb);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_miso", {31'd0, spi_miso}, 32'h0);
        check_eq("mid_rst_irq", {31'd0, irq}, 32'h0);
        bus_read(A_STATUS, rd); check_eq("mid_rst_status", rd, 32'h09);
        bus_read(A_CTRL, rd);   check_eq("mid_rst_ctrl", rd, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        bus_write(A_CTRL, 32'h0000_8007);
        for (int i = 4; i >= 0; i--) spi_bit(1'b0, 1'b0, d[i], i == 0, 1'b0, mb);
        spi_stop(1'b0);
        bus_read(A_STATUS, rd); check_eq("mid_rst_ignored", rd, 32'h09);
        bus_write(A_DATA, 32'h81);
        spi_frame(1'b0, 1'b0, 8, 32'h5A, 1'b0, m);
        check_eq("mid_rst_next_miso", m, 32'h81);
        bus_read(A_DATA, rd); check_eq("mid_rst_next_data", rd, 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
